// File: rtl/icache_pkg.sv
// Shared widths, FSM state type and PC split helper for the direct-mapped instruction cache.
package icache_pkg;

  localparam int unsigned DATA           = 32;
  localparam int unsigned ADDR           = 32;
  localparam int unsigned LINES          = 16;
  localparam int unsigned WORDS_PER_LINE = 4;
  localparam int unsigned MISS_W         = 32;

  localparam int unsigned OFF_W = $clog2(WORDS_PER_LINE);
  localparam int unsigned IDX_W = $clog2(LINES);
  localparam int unsigned TAG_W = ADDR - 2 - OFF_W - IDX_W;

  typedef enum logic [1:0] {
    IDLE,
    REFILL,
    DONE
  } state_t;

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [IDX_W-1:0] idx;
    logic [OFF_W-1:0] off;
  } addr_split_t;

  // Takes the word address (byte address without bits [1:0]).
  function automatic addr_split_t split_addr(input logic [ADDR-3:0] word_addr);
    return addr_split_t'(word_addr);
  endfunction

endpackage

// File: rtl/icache_if.sv
// Fetch-side and refill-memory-side signals of the instruction cache.
interface icache_if;
  import icache_pkg::*;

  logic              fetch_en;
  logic [ADDR-1:0]   PC;
  logic              flush;
  logic [DATA-1:0]   instr;
  logic              stall;
  logic              mem_req;
  logic [ADDR-1:0]   mem_addr;
  logic              mem_ready;
  logic [DATA-1:0]   mem_rdata;
  logic [MISS_W-1:0] miss_count;

  modport master (
    output fetch_en, PC, flush, mem_ready, mem_rdata,
    input  instr, stall, mem_req, mem_addr, miss_count
  );

  modport slave (
    input  fetch_en, PC, flush, mem_ready, mem_rdata,
    output instr, stall, mem_req, mem_addr, miss_count
  );

endinterface

// File: rtl/icache_store.sv
// Tag/valid/data storage: combinational lookup, single word write port, bulk invalidate.
module icache_store
  import icache_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clear_all,
  input  logic [IDX_W-1:0] rd_idx,
  input  logic [OFF_W-1:0] rd_off,
  input  logic [TAG_W-1:0] rd_tag,
  output logic             hit_c,
  output logic [DATA-1:0]  rd_data_c,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [OFF_W-1:0] wr_off,
  input  logic [DATA-1:0]  wr_data,
  input  logic             line_we,
  input  logic [TAG_W-1:0] wr_tag
);

  logic [LINES-1:0] valid_q;
  logic [TAG_W-1:0] tag_mem  [LINES];
  logic [DATA-1:0]  data_mem [LINES][WORDS_PER_LINE];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
    end else if (clear_all) begin
      valid_q <= '0;
    end else if (line_we) begin
      valid_q[wr_idx] <= 1'b1;
    end
  end

  // Payload arrays carry no reset; valid bits gate every read.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      data_mem[wr_idx][wr_off] <= wr_data;
    end
    if (line_we) begin
      tag_mem[wr_idx] <= wr_tag;
    end
  end

  assign hit_c     = valid_q[rd_idx] && (tag_mem[rd_idx] == rd_tag);
  assign rd_data_c = valid_q[rd_idx] ? data_mem[rd_idx][rd_off] : '0;

endmodule

// File: rtl/icache_ctrl.sv
// Direct-mapped I-cache controller: hit lookup, miss stall, line refill over req/ready, flush, miss counter.
module icache_ctrl
  import icache_pkg::*;
(
  input logic     clk,
  input logic     rst,
  icache_if.slave bus
);

  state_t            state_q, state_d;
  logic [OFF_W-1:0]  cnt_q, cnt_d;
  logic [TAG_W-1:0]  line_tag_q, line_tag_d;
  logic [IDX_W-1:0]  line_idx_q, line_idx_d;
  logic              req_q, req_d;
  logic [ADDR-1:0]   addr_q, addr_d;
  logic              flush_pend_q, flush_pend_d;
  logic [MISS_W-1:0] miss_q, miss_d;
  logic              wr_en, line_we, clear_all;
  logic              hit_c;
  logic [DATA-1:0]   rd_data_c;
  addr_split_t       pc_s;
  logic              unused_pc_bits;

  assign pc_s           = split_addr(bus.PC[ADDR-1:2]);
  assign unused_pc_bits = ^bus.PC[1:0];

  icache_store u_store (
    .clk       (clk),
    .rst       (rst),
    .clear_all (clear_all),
    .rd_idx    (pc_s.idx),
    .rd_off    (pc_s.off),
    .rd_tag    (pc_s.tag),
    .hit_c     (hit_c),
    .rd_data_c (rd_data_c),
    .wr_en     (wr_en),
    .wr_idx    (line_idx_q),
    .wr_off    (cnt_q),
    .wr_data   (bus.mem_rdata),
    .line_we   (line_we),
    .wr_tag    (line_tag_q)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      line_tag_q   <= '0;
      line_idx_q   <= '0;
      req_q        <= 1'b0;
      addr_q       <= '0;
      flush_pend_q <= 1'b0;
      miss_q       <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      line_tag_q   <= line_tag_d;
      line_idx_q   <= line_idx_d;
      req_q        <= req_d;
      addr_q       <= addr_d;
      flush_pend_q <= flush_pend_d;
      miss_q       <= miss_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    line_tag_d   = line_tag_q;
    line_idx_d   = line_idx_q;
    req_d        = req_q;
    addr_d       = addr_q;
    flush_pend_d = flush_pend_q;
    miss_d       = miss_q;
    wr_en        = 1'b0;
    line_we      = 1'b0;
    clear_all    = 1'b0;

    unique case (state_q)
      IDLE: begin
        // Flush takes priority over a miss seen in the same cycle.
        if (bus.flush) begin
          clear_all = 1'b1;
        end else if (bus.fetch_en && !hit_c) begin
          state_d    = REFILL;
          cnt_d      = '0;
          line_tag_d = pc_s.tag;
          line_idx_d = pc_s.idx;
          req_d      = 1'b1;
          addr_d     = {pc_s.tag, pc_s.idx, OFF_W'(0), 2'b00};
          if (miss_q != '1) begin
            miss_d = miss_q + MISS_W'(1);
          end
        end
      end
      REFILL: begin
        if (bus.flush) begin
          flush_pend_d = 1'b1;
        end
        if (bus.mem_ready) begin
          wr_en = 1'b1;
          cnt_d = cnt_q + OFF_W'(1);
          if (cnt_q == OFF_W'(WORDS_PER_LINE - 1)) begin
            line_we = 1'b1;
            req_d   = 1'b0;
            state_d = DONE;
          end else begin
            addr_d = addr_q + ADDR'(4);
          end
        end
      end
      DONE: begin
        // Deferred flush lands on the way back to IDLE, wiping the new line too.
        state_d      = IDLE;
        flush_pend_d = 1'b0;
        if (flush_pend_q || bus.flush) begin
          clear_all = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.stall      = bus.fetch_en && ((state_q != IDLE) || !hit_c || bus.flush);
  assign bus.instr      = rd_data_c;
  assign bus.mem_req    = req_q;
  assign bus.mem_addr   = addr_q;
  assign bus.miss_count = miss_q;

endmodule

// File: tb/tb_icache_ctrl.sv
// Directed bench for icache_ctrl; memory returns 0xA0 + word address for every refill word.
module tb_icache_ctrl;
  import icache_pkg::*;

  logic clk;
  logic rst;
  icache_if bus ();

  icache_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_checks;
  int          n_fail;
  int          cyc;
  int          nreq;
  logic [31:0] cap_addr [16];
  logic [31:0] exp_mc;

  // Advance to 1 time unit after the next rising edge and present the memory word.
  task automatic tick();
    @(posedge clk);
    #1;
    bus.mem_rdata = 32'hA0 + {2'b00, bus.mem_addr[31:2]};
  endtask

  // Fetch pc until stall drops; records stall cycles and requested addresses.
  task automatic run_fetch(input logic [31:0] pc, input logic [15:0] pat);
    int r;
    tick();
    bus.fetch_en  = 1'b1;
    bus.PC        = pc;
    bus.flush     = 1'b0;
    bus.mem_ready = 1'b0;
    cyc  = 0;
    nreq = 0;
    r    = 0;
    #1;
    while (bus.stall && cyc < 40) begin
      if (bus.mem_req) begin
        if (nreq < 16) cap_addr[nreq] = bus.mem_addr;
        bus.mem_ready = pat[r];
        nreq++;
        r = (r + 1) % 16;
      end else begin
        bus.mem_ready = 1'b0;
      end
      cyc++;
      tick();
      #1;
    end
    bus.mem_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst           = 1'b1;
    bus.fetch_en  = 1'b1;
    bus.PC        = 32'h0;
    bus.flush     = 1'b0;
    bus.mem_ready = 1'b0;
    bus.mem_rdata = 32'h0;
    #3;
    n_checks++; if (bus.stall !== 1'b1) begin n_fail++; $display("FAIL reset_stall: got %0b want 1", bus.stall); end
    n_checks++; if (bus.instr !== 32'h0) begin n_fail++; $display("FAIL reset_instr: got %0h want 0", bus.instr); end
    n_checks++; if (bus.mem_req !== 1'b0) begin n_fail++; $display("FAIL reset_mem_req: got %0b want 0", bus.mem_req); end
    n_checks++; if (bus.mem_addr !== 32'h0) begin n_fail++; $display("FAIL reset_mem_addr: got %0h want 0", bus.mem_addr); end
    n_checks++; if (bus.miss_count !== 32'h0) begin n_fail++; $display("FAIL reset_miss_count: got %0d want 0", bus.miss_count); end
    bus.fetch_en = 1'b0;
    tick();
    tick();
    rst    = 1'b0;
    exp_mc = 32'd0;
  endtask

  task automatic test_first_miss();
    run_fetch(32'h0, 16'hFFFF);
    exp_mc = 32'd1;
    n_checks++; if (cyc !== 6) begin n_fail++; $display("FAIL miss1_stall_cycles: got %0d want 6", cyc); end
    n_checks++; if (nreq !== 4) begin n_fail++; $display("FAIL miss1_req_cycles: got %0d want 4", nreq); end
    for (int k = 0; k < 4; k++) begin
      n_checks++; if (cap_addr[k] !== 32'(4 * k)) begin n_fail++; $display("FAIL miss1_addr%0d: got %0h want %0h", k, cap_addr[k], 4 * k); end
    end
    n_checks++; if (bus.instr !== 32'hA0) begin n_fail++; $display("FAIL miss1_instr: got %0h want a0", bus.instr); end
    n_checks++; if (bus.miss_count !== exp_mc) begin n_fail++; $display("FAIL miss1_count: got %0d want %0d", bus.miss_count, exp_mc); end
  endtask

  task automatic test_hits();
    for (int k = 1; k < 4; k++) begin
      tick();
      bus.PC        = 32'(4 * k);
      bus.mem_ready = 1'b1;
      #1;
      n_checks++; if (bus.stall !== 1'b0) begin n_fail++; $display("FAIL hit%0d_stall: got %0b want 0", k, bus.stall); end
      n_checks++; if (bus.instr !== 32'(32'hA0 + k)) begin n_fail++; $display("FAIL hit%0d_instr: got %0h want %0h", k, bus.instr, 32'hA0 + k); end
    end
    tick();
    bus.mem_ready = 1'b0;
    #1;
    n_checks++; if (bus.mem_req !== 1'b0) begin n_fail++; $display("FAIL hit_stray_ready: mem_req got %0b want 0", bus.mem_req); end
    n_checks++; if (bus.miss_count !== exp_mc) begin n_fail++; $display("FAIL hit_count: got %0d want %0d", bus.miss_count, exp_mc); end
  endtask

  task automatic test_conflict();
    run_fetch(32'h100, 16'hFFFF);
    exp_mc++;
    n_checks++; if (cyc !== 6) begin n_fail++; $display("FAIL conf_stall_cycles: got %0d want 6", cyc); end
    for (int k = 0; k < 4; k++) begin
      n_checks++; if (cap_addr[k] !== 32'(32'h100 + 4 * k)) begin n_fail++; $display("FAIL conf_addr%0d: got %0h want %0h", k, cap_addr[k], 32'h100 + 4 * k); end
    end
    n_checks++; if (bus.instr !== 32'hE0) begin n_fail++; $display("FAIL conf_instr: got %0h want e0", bus.instr); end
    run_fetch(32'h0, 16'hFFFF);
    exp_mc++;
    n_checks++; if (cyc !== 6) begin n_fail++; $display("FAIL conf_evict_cycles: got %0d want 6", cyc); end
    n_checks++; if (cap_addr[0] !== 32'h0) begin n_fail++; $display("FAIL conf_evict_addr: got %0h want 0", cap_addr[0]); end
    n_checks++; if (bus.instr !== 32'hA0) begin n_fail++; $display("FAIL conf_evict_instr: got %0h want a0", bus.instr); end
    n_checks++; if (bus.miss_count !== exp_mc) begin n_fail++; $display("FAIL conf_count: got %0d want %0d", bus.miss_count, exp_mc); end
  endtask

  task automatic test_ready_gaps();
    logic [31:0] want [6];
    want = '{32'h40, 32'h44, 32'h44, 32'h44, 32'h48, 32'h4C};
    run_fetch(32'h40, 16'h0039);
    exp_mc++;
    n_checks++; if (cyc !== 8) begin n_fail++; $display("FAIL gap_stall_cycles: got %0d want 8", cyc); end
    n_checks++; if (nreq !== 6) begin n_fail++; $display("FAIL gap_req_cycles: got %0d want 6", nreq); end
    for (int k = 0; k < 6; k++) begin
      n_checks++; if (cap_addr[k] !== want[k]) begin n_fail++; $display("FAIL gap_addr%0d: got %0h want %0h", k, cap_addr[k], want[k]); end
    end
    for (int k = 0; k < 4; k++) begin
      tick();
      bus.PC = 32'(32'h40 + 4 * k);
      #1;
      n_checks++; if (bus.stall !== 1'b0) begin n_fail++; $display("FAIL gap_hit%0d_stall: got %0b want 0", k, bus.stall); end
      n_checks++; if (bus.instr !== 32'(32'hB0 + k)) begin n_fail++; $display("FAIL gap_word%0d: got %0h want %0h", k, bus.instr, 32'hB0 + k); end
    end
  endtask

  task automatic test_flush();
    tick();
    bus.fetch_en = 1'b1; bus.PC = 32'h80; bus.mem_ready = 1'b1; bus.flush = 1'b0;
    #1;
    n_checks++; if (bus.stall !== 1'b1) begin n_fail++; $display("FAIL fl_miss_stall: got %0b want 1", bus.stall); end
    exp_mc++;
    tick();
    bus.flush = 1'b1;
    #1;
    n_checks++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h80) begin n_fail++; $display("FAIL fl_refill_req: got req %0b addr %0h want 1 80", bus.mem_req, bus.mem_addr); end
    tick();
    bus.flush = 1'b0;
    tick();
    tick();
    tick();
    #1;
    n_checks++; if (bus.mem_req !== 1'b0 || bus.stall !== 1'b1) begin n_fail++; $display("FAIL fl_done: got req %0b stall %0b want 0 1", bus.mem_req, bus.stall); end
    tick();
    #1;
    n_checks++; if (bus.stall !== 1'b1) begin n_fail++; $display("FAIL fl_remiss_stall: got %0b want 1", bus.stall); end
    n_checks++; if (bus.instr !== 32'h0) begin n_fail++; $display("FAIL fl_cleared_instr: got %0h want 0", bus.instr); end
    n_checks++; if (bus.miss_count !== exp_mc) begin n_fail++; $display("FAIL fl_count1: got %0d want %0d", bus.miss_count, exp_mc); end
    exp_mc++;
    tick();
    #1;
    n_checks++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h80) begin n_fail++; $display("FAIL fl_rerefill: got req %0b addr %0h want 1 80", bus.mem_req, bus.mem_addr); end
    n_checks++; if (bus.miss_count !== exp_mc) begin n_fail++; $display("FAIL fl_count2: got %0d want %0d", bus.miss_count, exp_mc); end
    repeat (4) tick();
    tick();
    #1;
    n_checks++; if (bus.stall !== 1'b0 || bus.instr !== 32'hC0) begin n_fail++; $display("FAIL fl_refetch: got stall %0b instr %0h want 0 c0", bus.stall, bus.instr); end
    // Flush together with a miss in IDLE: no refill, everything invalidated.
    tick();
    bus.PC = 32'hC0; bus.flush = 1'b1; bus.mem_ready = 1'b0;
    #1;
    n_checks++; if (bus.stall !== 1'b1) begin n_fail++; $display("FAIL flm_stall: got %0b want 1", bus.stall); end
    tick();
    bus.flush = 1'b0; bus.fetch_en = 1'b0; bus.PC = 32'h80;
    #1;
    n_checks++; if (bus.mem_req !== 1'b0) begin n_fail++; $display("FAIL flm_no_req: got %0b want 0", bus.mem_req); end
    n_checks++; if (bus.stall !== 1'b0) begin n_fail++; $display("FAIL flm_idle_stall: got %0b want 0", bus.stall); end
    n_checks++; if (bus.instr !== 32'h0) begin n_fail++; $display("FAIL flm_cleared: got %0h want 0", bus.instr); end
    n_checks++; if (bus.miss_count !== exp_mc) begin n_fail++; $display("FAIL flm_count: got %0d want %0d", bus.miss_count, exp_mc); end
    tick();
    #1;
    n_checks++; if (bus.mem_req !== 1'b0) begin n_fail++; $display("FAIL flm_no_req2: got %0b want 0", bus.mem_req); end
  endtask

  task automatic test_reset_mid_refill();
    tick();
    bus.fetch_en = 1'b1; bus.PC = 32'h0; bus.mem_ready = 1'b1;
    tick();
    tick();
    #1;
    n_checks++; if (bus.mem_req !== 1'b1) begin n_fail++; $display("FAIL rmr_in_refill: got %0b want 1", bus.mem_req); end
    rst = 1'b1;
    #1;
    n_checks++; if (bus.mem_req !== 1'b0) begin n_fail++; $display("FAIL rmr_req: got %0b want 0", bus.mem_req); end
    n_checks++; if (bus.stall !== 1'b1) begin n_fail++; $display("FAIL rmr_stall_hi: got %0b want 1", bus.stall); end
    n_checks++; if (bus.miss_count !== 32'h0) begin n_fail++; $display("FAIL rmr_count: got %0d want 0", bus.miss_count); end
    n_checks++; if (bus.mem_addr !== 32'h0) begin n_fail++; $display("FAIL rmr_addr: got %0h want 0", bus.mem_addr); end
    n_checks++; if (bus.instr !== 32'h0) begin n_fail++; $display("FAIL rmr_instr: got %0h want 0", bus.instr); end
    bus.fetch_en = 1'b0; bus.mem_ready = 1'b0;
    #1;
    n_checks++; if (bus.stall !== 1'b0) begin n_fail++; $display("FAIL rmr_stall_lo: got %0b want 0", bus.stall); end
    tick();
    rst    = 1'b0;
    exp_mc = 32'd0;
    run_fetch(32'h0, 16'hFFFF);
    exp_mc++;
    n_checks++; if (cyc !== 6) begin n_fail++; $display("FAIL rmr_refill_cycles: got %0d want 6", cyc); end
    for (int k = 0; k < 4; k++) begin
      n_checks++; if (cap_addr[k] !== 32'(4 * k)) begin n_fail++; $display("FAIL rmr_addr%0d: got %0h want %0h", k, cap_addr[k], 4 * k); end
    end
    n_checks++; if (bus.instr !== 32'hA0) begin n_fail++; $display("FAIL rmr_instr_after: got %0h want a0", bus.instr); end
    n_checks++; if (bus.miss_count !== exp_mc) begin n_fail++; $display("FAIL rmr_count_after: got %0d want %0d", bus.miss_count, exp_mc); end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_first_miss();
    test_hits();
    test_conflict();
    test_ready_gaps();
    test_flush();
    test_reset_mid_refill();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
